piso_tx: RTL and testbench



---
 rtl/piso_tx.sv | 160 ++++++++++++++++
 tb/tb_piso_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx -- parallel-in serial-out transmitter.
//
// Accepts a WIDTH-bit word on a valid/ready handshake. It then shifts the word
// out one bit per clk rising edge on d_out, with frame qualifiers. This is the
// transmit end of the link that the `sipo` block receives. With LSB_FIRST=0 the
// MSB goes first, which matches the sipo shift-left convention.
//
// Optional feature (compile-time macro PIPO_PARITY_EN):
//   When defined, an even-parity bit (XOR of the loaded word) follows the last
//   data bit. The frame is then WIDTH+1 cycles long. done and load_ready move
//   to the parity cycle. When undefined, no parity state or logic exists.
//
// Parameters:
//   WIDTH      word width in bits, 2..32
//   LSB_FIRST  0 = MSB first, 1 = LSB first
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset (priority over all inputs)
//   d_in        parallel word to transmit
//   load_valid  d_in is valid for loading
//   load_ready  transmitter accepts a word this cycle (combinational)
//   d_out       serial data bit (registered)
//   dout_valid  d_out carries a frame bit this cycle (registered)
//   done        one-cycle pulse coincident with the final frame bit (registered)
// -----------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             d_out,
    output logic             dout_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             d_out_nxt, dout_valid_nxt, done_nxt;
    logic             last_data, final_bit, accept;
    logic [CW-1:0]    cnt_inc;
`ifdef PIPO_PARITY_EN
    logic             par_q, par_nxt;
`endif

    // While in SHIFT, d_out is the bit at the "outgoing" end of sreg.
    // cnt is the index of that bit within the frame.
    assign last_data = (state == SHIFT) && (cnt == LAST_IDX);
    assign cnt_inc   = cnt + 1'b1;

`ifdef PIPO_PARITY_EN
    assign final_bit = (state == PAR);
`else
    assign final_bit = last_data;
`endif

    // Ready in the final-bit cycle lets the next frame follow with no gap.
    assign load_ready = (state == IDLE) || final_bit;
    assign accept     = load_valid && load_ready;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no
        // path leaves one unassigned, which would infer a latch.
        state_nxt      = state;
        sreg_nxt       = sreg;
        cnt_nxt        = cnt;
        d_out_nxt      = 1'b0;
        dout_valid_nxt = 1'b0;
        done_nxt       = 1'b0;
`ifdef PIPO_PARITY_EN
        par_nxt        = par_q;
`endif

        if (accept) begin
            state_nxt      = SHIFT;
            sreg_nxt       = d_in;
            cnt_nxt        = '0;
            d_out_nxt      = LSB_FIRST ? d_in[0] : d_in[WIDTH-1];
            dout_valid_nxt = 1'b1;
`ifdef PIPO_PARITY_EN
            par_nxt        = ^d_in;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (last_data) begin
`ifdef PIPO_PARITY_EN
                        state_nxt      = PAR;
                        d_out_nxt      = par_q;
                        dout_valid_nxt = 1'b1;
                        done_nxt       = 1'b1;
`else
                        state_nxt      = IDLE;
`endif
                    end else begin
                        cnt_nxt        = cnt_inc;
                        dout_valid_nxt = 1'b1;
                        if (LSB_FIRST) begin
                            sreg_nxt  = sreg >> 1;
                            d_out_nxt = sreg[1];
                        end else begin
                            sreg_nxt  = sreg << 1;
                            d_out_nxt = sreg[WIDTH-2];
                        end
`ifndef PIPO_PARITY_EN
                        // done is registered, so raise it when entering the last data bit.
                        done_nxt = (cnt_inc == LAST_IDX);
`endif
                    end
                end
`ifdef PIPO_PARITY_EN
                PAR:     state_nxt = IDLE;
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so
        // every register samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            d_out      <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
`ifdef PIPO_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            cnt        <= cnt_nxt;
            d_out      <= d_out_nxt;
            dout_valid <= dout_valid_nxt;
            done       <= done_nxt;
`ifdef PIPO_PARITY_EN
            par_q      <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_tx -- self-checking bench for piso_tx (WIDTH=4, LSB_FIRST=0).
//
// A frame-level model turns each accepted word into a list of expected
// (bit, done) cycles. A negedge process compares the DUT with that model
// on every cycle. Directed sections pin the model with hand-computed
// literal values. A sipo-like receiver is modelled here for the loopback case.
// Honours PIPO_PARITY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_piso_tx;

    localparam int W = 4;
    localparam bit LSBF = 1'b0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] d_in = '0;
    logic         load_valid = 1'b0;
    logic         load_ready, d_out, dout_valid, done;

    int n_checks = 0;
    int n_pass   = 0;

    piso_tx #(.WIDTH(W), .LSB_FIRST(LSBF)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .d_out      (d_out),
        .dout_valid (dout_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- frame-level model ----------------
    logic       m_valid = 1'b0;
    logic       m_bit   = 1'b0;
    logic       m_done  = 1'b0;
    logic [1:0] m_q[$];          // {bit, done} for the cycles still to come
    logic       chk_en  = 1'b0;

    function automatic logic m_ready();
        return !m_valid || m_done;
    endfunction

    always @(posedge clk) begin
        logic [1:0] e;
        if (rst) begin
            m_q.delete();
            m_valid = 1'b0; m_bit = 1'b0; m_done = 1'b0;
        end else begin
            if (load_valid && m_ready()) begin
                int n;
`ifdef PIPO_PARITY_EN
                n = W + 1;
`else
                n = W;
`endif
                for (int i = 0; i < W; i++) begin
                    logic b;
                    b = LSBF ? d_in[i] : d_in[W-1-i];
                    m_q.push_back({b, (i == n - 1)});
                end
`ifdef PIPO_PARITY_EN
                m_q.push_back({^d_in, 1'b1});
`endif
            end
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_valid = 1'b1; m_bit = e[1]; m_done = e[0];
            end else begin
                m_valid = 1'b0; m_bit = 1'b0; m_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model d_out",      d_out,      m_bit);
            check("model dout_valid", dout_valid, m_valid);
            check("model done",       done,       m_done);
            check("model load_ready", load_ready, m_ready());
        end
    end

    // sipo-style receiver: shifts left every edge, fed by d_out
    logic [W-1:0] sipo_q = '0;
    always @(posedge clk) sipo_q <= {sipo_q[W-2:0], d_out};

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string name, input logic eb, input logic ev, input logic ed);
        check({name, " d_out"}, d_out, eb);
        check({name, " dout_valid"}, dout_valid, ev);
        check({name, " done"}, done, ed);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq;
        logic [9:0] pseq;

        // Reset: held two cycles, then five idle cycles
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_cyc("reset idle", 1'b0, 1'b0, 1'b0);
            check("reset load_ready", load_ready, 1'b1);
        end

`ifndef PIPO_PARITY_EN
        // Single word 1010
        d_in = 4'b1010; load_valid = 1'b1;
        step();
        load_valid = 1'b0; d_in = 4'b0101;   // late change must not matter
        seq = 8'b1010_0000;
        for (int i = 0; i < 4; i++) begin
            expect_cyc("single", seq[7-i], 1'b1, i == 3);
            if (i < 3) step();
        end
        step();
        expect_cyc("single end", 1'b0, 1'b0, 1'b0);

        // Back-to-back 1010 then 0110
        d_in = 4'b1010; load_valid = 1'b1;
        step();
        d_in = 4'b0110;
        seq = 8'b1010_0110;
        for (int i = 0; i < 8; i++) begin
            expect_cyc("b2b", seq[7-i], 1'b1, (i == 3) || (i == 7));
            check("b2b load_ready", load_ready, (i == 3) || (i == 7));
            if (i == 4) load_valid = 1'b0;
            if (i < 7) step();
        end
        step();
        expect_cyc("b2b end", 1'b0, 1'b0, 1'b0);

        // Reset mid-frame
        d_in = 4'b1111; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        expect_cyc("abort c1", 1'b1, 1'b1, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_cyc("abort c3", 1'b0, 1'b0, 1'b0);
        d_in = 4'b0001; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        seq = 8'b0001_0000;
        for (int i = 0; i < 4; i++) begin
            expect_cyc("after abort", seq[7-i], 1'b1, i == 3);
            step();
        end
        expect_cyc("after abort end", 1'b0, 1'b0, 1'b0);

        // Loopback into sipo receiver
        d_in = 4'b1101; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step(); step(); step();
        check("loop done", done, 1'b1);
        step();
        check("loopback sipo", sipo_q, 4'b1101);
`else
        // Parity: 1011 -> 1,0,1,1,p=1 ; 0011 -> 0,0,1,1,p=0 back-to-back
        d_in = 4'b1011; load_valid = 1'b1;
        step();
        d_in = 4'b0011;
        pseq = 10'b10111_00110;
        for (int i = 0; i < 10; i++) begin
            expect_cyc("parity", pseq[9-i], 1'b1, (i == 4) || (i == 9));
            check("parity load_ready", load_ready, (i == 4) || (i == 9));
            if (i == 5) load_valid = 1'b0;
            if (i < 9) step();
        end
        step();
        expect_cyc("parity end", 1'b0, 1'b0, 1'b0);
`endif

        // load_valid coincident with rst is dropped
        rst = 1'b1; d_in = 4'b1001; load_valid = 1'b1;
        step();
        rst = 1'b0; load_valid = 1'b0;
        expect_cyc("rst drops load", 1'b0, 1'b0, 1'b0);

        // Extra back-to-back patterns checked by the model only
        d_in = 4'b1001; load_valid = 1'b1;
        step();
        d_in = 4'b0111;
        repeat (W + 1) step();
        d_in = 4'b1100;
        repeat (W + 1) step();
        load_valid = 1'b0;
        repeat (2 * W + 4) step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
